entry_queue: RTL and testbench
==============================

// Module: entry_queue
// PURPOSE
//  Operator-input front end feeding the microprocessor's data_in/Enter pair. Captures the 8-bit
//  switch value on each Enter button press, after synchronizing the button and optionally
//  debouncing it, and queues the captured bytes in a small FIFO. Presents the head byte with a
//  valid/accept handshake, so bytes keyed in faster than the core consumes them are not lost.
// PARAMETERS
//  DEPTH            4    FIFO entries; power of two, >= 2
//  DEBOUNCE_CYCLES  16   consecutive stable cycles required before a level change is accepted (DEBOUNCE_EN only)
// PORTS
//  Clock     in   1  single system clock, all logic on posedge
//  Reset     in   1  synchronous, active-low reset
//  SwitchIn  in   8  operator data switches, assumed quasi-static around a press
//  EnterBtn  in   1  raw, asynchronous Enter push-button, active-high
//  Accept    in   1  consumer has taken DataOut this cycle
//  DataOut   out  8  head-of-queue byte -> microprocessor data_in
//  Enter     out  1  head valid (= !Empty) -> microprocessor Enter
//  Full      out  1  Count == DEPTH
//  Empty     out  1  Count == 0
//  Count     out  $clog2(DEPTH)+1  entries held
//  Overflow  out  1  sticky: a press was dropped while full
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): pointers=0, Count=0, Empty=1, Full=0, Enter=0, DataOut=8'h00,
//    Overflow=0. Synchronizer/debounce flops reset to 1, so a button held through reset release
//    produces no push until it is released and pressed again. Reset mid-queue discards all entries.
//  - EnterBtn passes through a 2-flop synchronizer. A push pulse (1 cycle) is generated on a
//    0->1 transition of the conditioned level; SwitchIn is sampled in the same cycle as the pulse.
//  - Latency without debounce: EnterBtn rises before edge N -> push at edge N+2 -> Enter=1 and
//    DataOut valid after edge N+3. No combinational bypass from SwitchIn to DataOut.
//  - Push when !Full: write at wr_ptr, wr_ptr++ (wraps modulo DEPTH).
//    Push when Full and no pop: byte dropped, Overflow<=1 (held until reset).
//  - Pop when Enter && Accept: rd_ptr++ (wraps). Accept while Empty is ignored.
//  - Simultaneous push and pop: both take effect, Count unchanged. This includes when Full:
//    the push is accepted and Overflow is not set.
//  - DataOut = mem[rd_ptr] when !Empty, else 8'h00. Enter is combinational from registered Count.
//  - Count width rules: Count computed at full width, never exceeds DEPTH, never underflows.
// CONFIGURATION
//  DEBOUNCE_EN defined: the synchronized level drives a counter. Any change from the current
//    accepted level must persist DEBOUNCE_CYCLES consecutive cycles before being accepted. Any
//    bounce reloads the counter. Push latency becomes 2+DEBOUNCE_CYCLES cycles.
//  DEBOUNCE_EN undefined: the synchronized level is used directly. DEBOUNCE_CYCLES is unused,
//    with no counter logic.
// STRUCTURE
//  Package entry_pkg: DATA_W=8, default DEPTH, PTR_W/CNT_W derivations.
//  Sub-module entry_debounce: synchronizer, optional debounce counter and rising-edge detect.
//    Output is push_pulse. entry_queue holds the FIFO storage, pointers, Count and flags.
// TESTING
//  1 Reset low 3 cycles while EnterBtn=1, release -> no push, Empty=1, Enter=0, DataOut=00, until button re-pressed.
//  2 No debounce: SwitchIn=8'd10, press -> Enter=1, DataOut=0A exactly 3 cycles after press;
//    Accept=1 for 1 cycle -> Empty=1.
//  3 Press 10,20,30,40 with Accept=0 -> Full=1, Count=4; press 50 -> Overflow=1, 50 discarded;
//    drain -> 0A,14,1E,28 in order.
//  4 Full, with a press and Accept arriving on the same cycle -> Count stays 4, Overflow=0,
//    new byte appears after three drains (pointer wrap).
//  5 DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle glitch pulses -> no push; clean 20-cycle press
//    -> exactly one push at 2+16 cycles.
//  6 Reset asserted with Count=3 -> next cycle Count=0, Enter=0, Overflow=0.

Source files
------------

// File: rtl/entry_pkg.sv
// Shared widths and defaults for the operator entry queue.
// Build option: DEBOUNCE_EN enables the button debounce counter.
package entry_pkg;

    localparam int DATA_W       = 8;
    localparam int DEPTH_DEF    = 4;
    localparam int DEBOUNCE_DEF = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/entry_debounce.sv
// Enter button conditioning: 2-flop sync, optional debounce, rising-edge pulse.
// Build option: DEBOUNCE_EN adds the stability counter.
module entry_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic push_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic push_q;
    logic level;

    // Reset high so a button held through reset needs a fresh press.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(CYCLES - 1);

    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CMAX) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lvl_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = lvl_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
            push_q <= 1'b0;
        end else begin
            prev_q <= level;
            push_q <= level & ~prev_q;
        end
    end

    assign push_o = push_q;

endmodule

// File: rtl/entry_queue.sv
// Operator entry front end: captures SwitchIn on each Enter press into a FIFO.
// Build option: DEBOUNCE_EN debounces the Enter button before edge detect.
module entry_queue
    import entry_pkg::*;
#(
    parameter int DEPTH           = DEPTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [DATA_W-1:0]         SwitchIn,
    input  logic                      EnterBtn,
    input  logic                      Accept,
    output logic [DATA_W-1:0]         DataOut,
    output logic                      Enter,
    output logic                      Full,
    output logic                      Empty,
    output logic [cnt_w(DEPTH)-1:0]   Count,
    output logic                      Overflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              push;
    logic              do_push;
    logic              do_pop;

    entry_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .btn_i  (EnterBtn),
        .push_o (push)
    );

    assign Empty = (count_q == '0);
    assign Full  = (count_q == FULL_CNT);
    assign Enter = ~Empty;
    assign Count = count_q;
    assign Overflow = ovf_q;
    assign DataOut = Empty ? '0 : mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot, so a push into a full queue is kept.
    assign do_pop  = Enter & Accept;
    assign do_push = push & (~Full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= SwitchIn;
        end
    end

endmodule

// File: tb/tb_entry_queue.sv
// Directed self-checking bench for entry_queue (DEPTH=4, DEBOUNCE_CYCLES=16).
module tb_entry_queue;
    import entry_pkg::*;

`ifdef DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT  = 2 + DB;
    localparam int HOLD = (DB == 0) ? 2 : DB + 4;
    localparam int REL  = (DB == 0) ? 3 : DB + 4;

    logic       Clock;
    logic       Reset;
    logic [7:0] SwitchIn;
    logic       EnterBtn;
    logic       Accept;
    logic [7:0] DataOut;
    logic       Enter;
    logic       Full;
    logic       Empty;
    logic [2:0] Count;
    logic       Overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] cnt;
        logic       full;
        logic       ovf;
        logic [7:0] head;
    } vec_t;

    vec_t       tv [5];
    logic [7:0] dexp [4];

    entry_queue #(
        .DEPTH           (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SwitchIn (SwitchIn),
        .EnterBtn (EnterBtn),
        .Accept   (Accept),
        .DataOut  (DataOut),
        .Enter    (Enter),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count),
        .Overflow (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One press; optional Accept lands on the same edge as the write.
    task automatic press(input logic [7:0] v, input bit acc);
        SwitchIn = v;
        for (int i = 0; i < HOLD + REL; i++) begin
            EnterBtn = (i < HOLD);
            Accept   = acc && (i == LAT + 1);
            step(1);
        end
        EnterBtn = 1'b0;
        Accept   = 1'b0;
    endtask

    task automatic pop1();
        Accept = 1'b1;
        step(1);
        Accept = 1'b0;
    endtask

    initial begin
        tv[0] = '{8'd10, 3'd1, 1'b0, 1'b0, 8'h0A};
        tv[1] = '{8'd20, 3'd2, 1'b0, 1'b0, 8'h0A};
        tv[2] = '{8'd30, 3'd3, 1'b0, 1'b0, 8'h0A};
        tv[3] = '{8'd40, 3'd4, 1'b1, 1'b0, 8'h0A};
        tv[4] = '{8'd50, 3'd4, 1'b1, 1'b1, 8'h0A};
        dexp[0] = 8'h0A;
        dexp[1] = 8'h14;
        dexp[2] = 8'h1E;
        dexp[3] = 8'h28;

        Reset    = 1'b0;
        EnterBtn = 1'b1;
        Accept   = 1'b0;
        SwitchIn = 8'h77;
        step(3);
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        Reset = 1'b1;
        step(LAT + 4);
        chk("held_empty", Empty, 1);
        chk("held_enter", Enter, 0);
        chk("held_data", DataOut, 8'h00);
        chk("held_full", Full, 0);
        chk("held_ovf", Overflow, 0);
        EnterBtn = 1'b0;
        step(REL);
        chk("release_empty", Empty, 1);

`ifdef DEBOUNCE_EN
        for (int r = 0; r < 3; r++) begin
            EnterBtn = 1'b1;
            step(5);
            EnterBtn = 1'b0;
            step(10);
            chk("glitch_count", Count, 0);
        end
        step(REL);
`endif

        SwitchIn = 8'd10;
        for (int i = 0; i < HOLD + REL; i++) begin
            EnterBtn = (i < HOLD);
            step(1);
            if (i + 1 == LAT + 1) chk("lat_enter_early", Enter, 0);
            if (i + 1 == LAT + 2) begin
                chk("lat_enter", Enter, 1);
                chk("lat_data", DataOut, 8'h0A);
            end
        end
        EnterBtn = 1'b0;
        chk("single_push", Count, 1);
        pop1();
        chk("pop_empty", Empty, 1);
        chk("pop_enter", Enter, 0);
        chk("pop_data", DataOut, 8'h00);
        pop1();
        chk("accept_when_empty", Count, 0);

        for (int i = 0; i < 5; i++) begin
            press(tv[i].sw, 1'b0);
            chk("fill_count", Count, tv[i].cnt);
            chk("fill_full", Full, tv[i].full);
            chk("fill_ovf", Overflow, tv[i].ovf);
            chk("fill_head", DataOut, tv[i].head);
        end
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", DataOut, dexp[i]);
            pop1();
            chk("drain_count", Count, 3 - i);
        end
        chk("drain_empty", Empty, 1);
        chk("ovf_sticky", Overflow, 1);

        press(8'h31, 1'b0);
        press(8'h32, 1'b0);
        press(8'h33, 1'b0);
        chk("pre_rst_count", Count, 3);
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
        chk("midrst_count", Count, 0);
        chk("midrst_enter", Enter, 0);
        chk("midrst_ovf", Overflow, 0);
        chk("midrst_data", DataOut, 8'h00);
        step(1);

        press(8'hA1, 1'b0);
        press(8'hA2, 1'b0);
        press(8'hA3, 1'b0);
        press(8'hA4, 1'b0);
        chk("full_again", Full, 1);
        press(8'h55, 1'b1);
        chk("pp_count", Count, 4);
        chk("pp_ovf", Overflow, 0);
        chk("pp_head", DataOut, 8'hA2);
        pop1();
        chk("wrap_head1", DataOut, 8'hA3);
        pop1();
        chk("wrap_head2", DataOut, 8'hA4);
        pop1();
        chk("wrap_head3", DataOut, 8'h55);
        pop1();
        chk("wrap_empty", Empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
